// File: rtl/tt_chk_pkg.sv
// Shared definitions for the truth-table response checker:
// FSM state encoding, MISR polynomial and error-count ceiling.
package tt_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // x^16 + x^12 + x^5 + 1; the x^16 term is implicit in the shift.
  localparam logic [15:0] MISR_POLY = 16'h1021;

  localparam logic [4:0] ERR_MAX = 5'd31;

endpackage

// File: rtl/tt_misr16.sv
// 16-bit single-input signature register (Galois form) compacting the
// response stream of a check run.
module tt_misr16
  import tt_chk_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift_en,
  input  logic        din,
  output logic [15:0] signature
);

  logic feedback;

  assign feedback = signature[15] ^ din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signature <= '0;
    end else if (clear) begin
      signature <= '0;
    end else if (shift_en) begin
      signature <= {signature[14:0], 1'b0} ^ (feedback ? MISR_POLY : '0);
    end
  end

endmodule

// File: rtl/tt_response_checker.sv
// Checks a 4-input DUT response stream against an expected truth table.
// Define CHK_SIGNATURE_EN to add a MISR signature output over accepted samples.
module tt_response_checker
  import tt_chk_pkg::*;
#(
  parameter logic [15:0] EXP_TT = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        vec_valid,
  input  logic [3:0]  vec,
  input  logic        f,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  err_count,
  output logic        first_err_valid,
  output logic [3:0]  first_err_vec,
  output logic [15:0] coverage
`ifdef CHK_SIGNATURE_EN
  ,
  output logic [15:0] signature
`endif
);

  state_t      state, state_next;
  logic [4:0]  err_next;
  logic        fev_next;
  logic [3:0]  fvec_next;
  logic [15:0] cov_next;
  logic        accept;
  logic        mismatch;

  // A start pulse takes priority, so a sample in the start cycle is dropped.
  assign accept = (state == RUN) && vec_valid && !start;

  always_comb begin
    state_next = state;
    err_next   = err_count;
    fev_next   = first_err_valid;
    fvec_next  = first_err_vec;
    cov_next   = coverage;
    mismatch   = 1'b0;
    if (start) begin
      state_next = RUN;
      err_next   = '0;
      fev_next   = 1'b0;
      fvec_next  = '0;
      cov_next   = '0;
    end else if (accept) begin
      mismatch = (f != EXP_TT[vec]);
      cov_next = coverage | (16'h0001 << vec);
      if (mismatch) begin
        if (err_count != ERR_MAX) begin
          err_next = err_count + 5'd1;
        end
        if (!first_err_valid) begin
          fev_next  = 1'b1;
          fvec_next = vec;
        end
      end
      if (cov_next == '1) begin
        state_next = DONE;
      end
    end
  end

  // Status flags are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
      coverage        <= '0;
    end else begin
      state           <= state_next;
      busy            <= (state_next == RUN);
      done            <= (state_next == DONE);
      pass            <= (state_next == DONE) && (err_next == '0);
      err_count       <= err_next;
      first_err_valid <= fev_next;
      first_err_vec   <= fvec_next;
      coverage        <= cov_next;
    end
  end

`ifdef CHK_SIGNATURE_EN
  tt_misr16 u_misr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start),
    .shift_en  (accept),
    .din       (f),
    .signature (signature)
  );
`endif

endmodule

// File: tb/tb_tt_response_checker.sv
// Scoreboard bench for tt_response_checker: the driver pushes expected
// outputs from a behavioural model, a monitor pops and compares each cycle.
module tb_tt_response_checker;

  localparam logic [15:0] TT = 16'hA5C3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        vec_valid = 1'b0;
  logic [3:0]  vec = '0;
  logic        f = 1'b0;
  logic        busy, done, pass, first_err_valid;
  logic [4:0]  err_count;
  logic [3:0]  first_err_vec;
  logic [15:0] coverage;
`ifdef CHK_SIGNATURE_EN
  logic [15:0] signature;
`endif

  always #5 clk = ~clk;

  tt_response_checker #(.EXP_TT(TT)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .vec_valid       (vec_valid),
    .vec             (vec),
    .f               (f),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_count       (err_count),
    .first_err_valid (first_err_valid),
    .first_err_vec   (first_err_vec),
    .coverage        (coverage)
`ifdef CHK_SIGNATURE_EN
    ,
    .signature       (signature)
`endif
  );

  typedef struct {
    logic        busy;
    logic        done;
    logic        pass;
    logic [4:0]  err;
    logic        fev;
    logic [3:0]  fvec;
    logic [15:0] cov;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: mode 0 = idle, 1 = checking, 2 = finished.
  int   m_mode = 0;
  bit   m_seen[16];
  int   m_err = 0;
  bit   m_fev = 1'b0;
  int   m_fvec = 0;

  function automatic logic good(input logic [3:0] v);
    logic [15:0] tt;
    tt = TT;
    return tt[v];
  endfunction

  function automatic bit all_seen();
    for (int i = 0; i < 16; i++) if (!m_seen[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic exp_t snapshot();
    exp_t e;
    e.busy = (m_mode == 1);
    e.done = (m_mode == 2);
    e.pass = (m_mode == 2) && (m_err == 0);
    e.err  = 5'(m_err);
    e.fev  = m_fev;
    e.fvec = 4'(m_fvec);
    e.cov  = '0;
    for (int i = 0; i < 16; i++) e.cov[i] = m_seen[i];
    return e;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 16; i++) m_seen[i] = 1'b0;
    m_err  = 0;
    m_fev  = 1'b0;
    m_fvec = 0;
  endtask

  task automatic step(input logic r, input logic s, input logic vv,
                      input logic [3:0] v, input logic ff);
    @(negedge clk);
    #1;
    rst_n = r; start = s; vec_valid = vv; vec = v; f = ff;
    if (!r) begin
      m_mode = 0;
      clear_model();
    end else if (s) begin
      m_mode = 1;
      clear_model();
    end else if (m_mode == 1 && vv) begin
      m_seen[v] = 1'b1;
      if (ff != good(v)) begin
        if (m_err < 31) m_err++;
        if (!m_fev) begin
          m_fev  = 1'b1;
          m_fvec = int'(v);
        end
      end
      if (all_seen()) m_mode = 2;
    end
    q.push_back(snapshot());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 4'($urandom), 1'($urandom));
  endtask

  task automatic sweep(input logic [15:0] flip);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b1, 4'(i), good(4'(i)) ^ flip[i]);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("busy",            16'(busy),            16'(e.busy));
        chk("done",            16'(done),            16'(e.done));
        chk("pass",            16'(pass),            16'(e.pass));
        chk("err_count",       16'(err_count),       16'(e.err));
        chk("first_err_valid", 16'(first_err_valid), 16'(e.fev));
        chk("first_err_vec",   16'(first_err_vec),   16'(e.fvec));
        chk("coverage",        coverage,             e.cov);
      end
    end
  end

`ifdef CHK_SIGNATURE_EN
  logic [15:0] sig_a, sig_b, sig_c;

  task automatic sig_run(input logic [15:0] flip, output logic [15:0] sig);
    step(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    sweep(flip);
    idle(2);
    @(negedge clk);
    #2;
    sig = signature;
  endtask
`endif

  initial begin : driver
    int waited;
    logic [3:0] v;
    // Reset held for a few cycles, then samples without start are ignored.
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 4'h3, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 4'($urandom), 1'($urandom));

    // Clean ascending run.
    step(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    sweep(16'h0000);
    // Samples in DONE leave results unchanged.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 4'($urandom), 1'($urandom));

    // Errors at 5 and 9; a sample in the start cycle is dropped.
    step(1'b1, 1'b1, 1'b1, 4'h2, ~good(4'h2));
    sweep(16'h0220);
    idle(2);

    // Saturation: 40 wrong samples of vector 3, then a clean sweep.
    step(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b1, 4'h3, ~good(4'h3));
    sweep(16'h0000);
    idle(1);

    // Start in DONE then vector 0 only.
    step(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 4'h0, good(4'h0));
    idle(2);

    // Reset mid-run after 8 vectors, then samples without start.
    step(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 4'(i), ~good(4'(i)));
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 4'($urandom), 1'($urandom));

    // Randomised runs: random order, gaps, errors and occasional restarts.
    for (int r = 0; r < 6; r++) begin
      step(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
      for (int c = 0; c < 300 && m_mode == 1; c++) begin
        v = 4'($urandom);
        step(1'b1, ($urandom % 150) == 0, ($urandom % 4) != 0, v,
             good(v) ^ (($urandom % 6) == 0));
      end
      idle(2);
    end

`ifdef CHK_SIGNATURE_EN
    sig_run(16'h0000, sig_a);
    sig_run(16'h0000, sig_b);
    sig_run(16'h0080, sig_c);
    checks++;
    if (sig_a == 16'h0000) begin
      errors++;
      $display("FAIL signature_nonzero: got %h expected nonzero", sig_a);
    end
    checks++;
    if (sig_a !== sig_b) begin
      errors++;
      $display("FAIL signature_repeat: got %h expected %h", sig_b, sig_a);
    end
    checks++;
    if (sig_c === sig_a) begin
      errors++;
      $display("FAIL signature_flip: got %h expected value other than %h", sig_c, sig_a);
    end
`endif

    idle(1);
    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    #2;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_response_checker.md
TT_RESPONSE_CHECKER -- requirements
Module: tt_response_checker

Interface
REQ-001 SHALL have parameter EXP_TT, default 16'h0000: expected truth table, bit i = expected f for vector i ({x1,x2,x3,x4} = i).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle pulse: clear results, begin a check run.
REQ-005 SHALL have port vec_valid  input  1  vec and f are stable and valid this cycle.
REQ-006 SHALL have port vec  input  4  applied stimulus, bit3 = x1 ... bit0 = x4.
REQ-007 SHALL have port f  input  1  DUT response to vec.
REQ-008 SHALL have port busy  output  1  high in RUN.
REQ-009 SHALL have port done  output  1  high in DONE.
REQ-010 SHALL have port pass  output  1  high in DONE when err_count == 0.
REQ-011 SHALL have port err_count  output  5  mismatches in current run, saturating.
REQ-012 SHALL have port first_err_valid  output  1  at least one mismatch recorded.
REQ-013 SHALL have port first_err_vec  output  4  vector of first mismatch; 4'h0 when none.
REQ-014 SHALL have port coverage  output  16  bit i set once vector i sampled in current run.

Function
REQ-015 SHALL implement FSM IDLE -> RUN on start; RUN -> DONE when coverage reaches 16'hFFFF; DONE -> RUN on start.
REQ-016 SHALL, on start (any state), clear err_count, coverage, first_err_*, signature, and enter RUN next edge; a vec_valid in the start cycle is ignored.
REQ-017 SHALL, in RUN with vec_valid, compare f against EXP_TT[vec] and set coverage[vec] on that edge.
REQ-018 SHALL increment err_count on mismatch, saturating at 5'd31; repeated vectors are rechecked and counted again.
REQ-019 SHALL capture first_err_vec and set first_err_valid only on the first mismatch of a run.
REQ-020 SHALL enter DONE on the same edge that samples the last uncovered vector; done/pass visible the following cycle.
REQ-021 SHALL ignore vec_valid in IDLE and DONE; all outputs hold.
REQ-022 SHALL register all outputs; no combinational path from inputs to outputs.

Reset
REQ-023 SHALL, while rst_n low, force IDLE, busy=0, done=0, pass=0, err_count=0, first_err_valid=0, first_err_vec=0, coverage=0, signature=0.
REQ-024 SHALL, on reset mid-run, discard all partial results; a new start is required.

Configuration
REQ-025 SHALL, with CHK_SIGNATURE_EN defined, add output signature (16) and a MISR, polynomial x^16+x^12+x^5+1, shifting in f on every accepted sample.
REQ-026 SHALL, without CHK_SIGNATURE_EN, omit the signature port and all MISR logic; all other behaviour is unchanged.

Structure
REQ-027 SHALL place FSM state typedef (IDLE/RUN/DONE), MISR polynomial constant and ERR_MAX (5'd31) in shared package tt_chk_pkg.
REQ-028 SHALL implement the MISR as sub-module tt_misr16, instantiated only under CHK_SIGNATURE_EN.

Verification
REQ-029 SHALL cover: EXP_TT=16'hA5C3, start, vectors 0..15 ascending with correct f -> done=1, pass=1, err_count=0, coverage=16'hFFFF.
REQ-030 SHALL cover: same, f inverted at vectors 5 and 9 -> done=1, pass=0, err_count=2, first_err_vec=4'h5.
REQ-031 SHALL cover: 40 samples of vector 3 with wrong f, then 0..15 correct -> err_count=31 (saturated), done only after vector 15.
REQ-032 SHALL cover: rst_n low after 8 vectors -> all outputs 0, IDLE; vec_valid pulses without start leave coverage=0.
REQ-033 SHALL cover: start in DONE, then vector 0 only -> coverage=16'h0001, busy=1, done=0, err_count cleared.
REQ-034 SHALL cover (CHK_SIGNATURE_EN): two identical passing runs -> identical nonzero signature; single flipped f -> different signature.
